// File: rtl/rd_wptr_sync.sv
`default_nettype none
// ============================================================================
// Module      : rd_wptr_sync
// Description : Read-domain receiver for the async FIFO gray write pointer.
//               Synchronizes gwptr into r_clk, converts it to binary, and
//               produces registered occupancy, almost-empty and a sticky
//               gray-coherence error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_wptr_sync #(
    parameter int N           = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AE_LEVEL    = 1
) (
    input  logic       r_clk,
    input  logic       r_reset,
    input  logic [N:0] gwptr,
    input  logic [N:0] brptr,
    input  logic       err_clr,
    output logic [N:0] gwptrsyn,
    output logic [N:0] bwptrsyn,
    output logic [N:0] rd_count,
    output logic       almost_empty,
    output logic       gray_err
);

    // Full FIFO occupancy (2^N) and the almost-empty threshold at pointer width.
    localparam logic [N:0] c_depth    = {1'b1, {N{1'b0}}};
    localparam logic [N:0] c_ae_level = (N+1)'(AE_LEVEL);

    // Synchronizer chain, stage 0 is the first flop after the clock crossing.
    logic [SYNC_STAGES-1:0][N:0] sync_q;
    logic [SYNC_STAGES-1:0][N:0] sync_d;

    // Previous synchronized pointer, used for the one-bit-change check.
    logic [N:0] prev_q;
    logic [N:0] prev_d;

    // Registered outputs.
    logic [N:0] bwptrsyn_q;
    logic [N:0] bwptrsyn_d;
    logic [N:0] rd_count_q;
    logic [N:0] rd_count_d;
    logic       almost_empty_q;
    logic       almost_empty_d;
    logic       gray_err_q;
    logic       gray_err_d;

    // Combinational helpers.
    logic [N:0] bin_w;
    logic [N:0] flip_w;
    logic       multi_flip_w;
    logic       err_set_w;

    assign gwptrsyn = sync_q[SYNC_STAGES-1];

    // Shift the chain: gwptr enters stage 0 with no logic in front of it.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], gwptr};
    end

    // Gray-to-binary conversion of the synchronized pointer, MSB down.
    always_comb begin
        bin_w    = '0;
        bin_w[N] = gwptrsyn[N];
        for (int i = N - 1; i >= 0; i--) begin
            bin_w[i] = bin_w[i+1] ^ gwptrsyn[i];
        end
    end

    // Next-state for occupancy, almost-empty and the sticky coherence flag.
    always_comb begin
        prev_d         = gwptrsyn;
        bwptrsyn_d     = bin_w;
        rd_count_d     = bin_w - brptr;
        almost_empty_d = (rd_count_d <= c_ae_level);
        // x & (x-1) is non-zero exactly when more than one bit flipped.
        flip_w         = gwptrsyn ^ prev_q;
        multi_flip_w   = |(flip_w & (flip_w - 1'b1));
        err_set_w      = multi_flip_w || (rd_count_d > c_depth);
        if (err_set_w) begin
            gray_err_d = 1'b1;
        end else if (err_clr) begin
            gray_err_d = 1'b0;
        end else begin
            gray_err_d = gray_err_q;
        end
    end

    // All state flops; asynchronous active-low reset clears to idle/empty.
    always_ff @(posedge r_clk or negedge r_reset) begin
        if (!r_reset) begin
            sync_q         <= '0;
            prev_q         <= '0;
            bwptrsyn_q     <= '0;
            rd_count_q     <= '0;
            almost_empty_q <= 1'b1;
            gray_err_q     <= 1'b0;
        end else begin
            sync_q         <= sync_d;
            prev_q         <= prev_d;
            bwptrsyn_q     <= bwptrsyn_d;
            rd_count_q     <= rd_count_d;
            almost_empty_q <= almost_empty_d;
            gray_err_q     <= gray_err_d;
        end
    end

    assign bwptrsyn     = bwptrsyn_q;
    assign rd_count     = rd_count_q;
    assign almost_empty = almost_empty_q;
    assign gray_err     = gray_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rd_wptr_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_rd_wptr_sync
// Description : Scoreboard bench for rd_wptr_sync with a history-based
//               reference model, directed scenarios and a random phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rd_wptr_sync;

    localparam int N     = 3;
    localparam int S     = 2;
    localparam int AE    = 1;
    localparam int DEPTH = 8;
    localparam int MOD   = 16;

    logic         r_clk   = 1'b0;
    logic         r_reset = 1'b0;
    logic [N:0]   gwptr;
    logic [N:0]   brptr;
    logic         err_clr;
    logic [N:0]   gwptrsyn;
    logic [N:0]   bwptrsyn;
    logic [N:0]   rd_count;
    logic         almost_empty;
    logic         gray_err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [N:0] syn;
        logic [N:0] bw;
        logic [N:0] cnt;
        logic       ae;
        logic       err;
    } exp_t;

    exp_t expq[$];

    rd_wptr_sync #(
        .N           (N),
        .SYNC_STAGES (S),
        .AE_LEVEL    (AE)
    ) dut (
        .r_clk        (r_clk),
        .r_reset      (r_reset),
        .gwptr        (gwptr),
        .brptr        (brptr),
        .err_clr      (err_clr),
        .gwptrsyn     (gwptrsyn),
        .bwptrsyn     (bwptrsyn),
        .rd_count     (rd_count),
        .almost_empty (almost_empty),
        .gray_err     (gray_err)
    );

    always #5 r_clk = ~r_clk;

    function automatic logic [N:0] gray(input int x);
        int m;
        m = x % MOD;
        return 4'(m ^ (m >> 1));
    endfunction

    // Binary value of a gray code: XOR of all right shifts of the code.
    function automatic int bin_of(input logic [N:0] g);
        int b;
        b = 0;
        for (int s = 0; s <= N; s++) begin
            b = b ^ (int'(g) >> s);
        end
        return b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: history of sampled write pointers since reset.
    logic [N:0] m_hist[$];
    logic [N:0] m_syn1;
    logic [N:0] m_syn2;
    logic [N:0] m_synk;
    bit         m_err;
    int         m_bp;
    int         m_occ;
    exp_t       m_e;

    initial begin
        forever begin
            @(posedge r_clk or negedge r_reset);
            if (!r_reset) begin
                m_hist.delete();
                for (int i = 0; i < S - 1; i++) m_hist.push_back('0);
                m_syn1 = '0;
                m_syn2 = '0;
                m_err  = 1'b0;
                expq.delete();
            end else begin
                m_bp  = bin_of(m_syn1);
                m_occ = (m_bp - int'(brptr) + MOD) % MOD;
                if ($countones(m_syn1 ^ m_syn2) > 1 || m_occ > DEPTH) m_err = 1'b1;
                else if (err_clr) m_err = 1'b0;
                m_hist.push_front(gwptr);
                m_synk = m_hist[S-1];
                void'(m_hist.pop_back());
                m_e.syn = m_synk;
                m_e.bw  = 4'(m_bp);
                m_e.cnt = 4'(m_occ);
                m_e.ae  = (m_occ <= AE);
                m_e.err = m_err;
                expq.push_back(m_e);
                m_syn2 = m_syn1;
                m_syn1 = m_synk;
            end
        end
    end

    // Monitor: the DUT presents a new output set every cycle.
    exp_t mon_e;
    initial begin
        forever begin
            @(negedge r_clk);
            if (!r_reset) begin
                chk("rst_gwptrsyn", 32'(gwptrsyn), 32'd0);
                chk("rst_bwptrsyn", 32'(bwptrsyn), 32'd0);
                chk("rst_rd_count", 32'(rd_count), 32'd0);
                chk("rst_almost_empty", 32'(almost_empty), 32'd1);
                chk("rst_gray_err", 32'(gray_err), 32'd0);
            end else if (expq.size() > 0) begin
                mon_e = expq.pop_front();
                chk("gwptrsyn", 32'(gwptrsyn), 32'(mon_e.syn));
                chk("bwptrsyn", 32'(bwptrsyn), 32'(mon_e.bw));
                chk("rd_count", 32'(rd_count), 32'(mon_e.cnt));
                chk("almost_empty", 32'(almost_empty), 32'(mon_e.ae));
                chk("gray_err", 32'(gray_err), 32'(mon_e.err));
            end
        end
    end

    task automatic cyc(input logic [N:0] g, input logic [N:0] b, input logic c);
        gwptr   = g;
        brptr   = b;
        err_clr = c;
        @(posedge r_clk);
        #2;
    endtask

    initial begin
        int wi;
        int rb;
        int r;

        // Reset held with a non-zero pointer on the input.
        gwptr   = 4'b0101;
        brptr   = '0;
        err_clr = 1'b0;
        r_reset = 1'b0;
        repeat (4) @(posedge r_clk);
        #2;
        gwptr   = '0;
        r_reset = 1'b1;
        repeat (4) cyc(gray(0), 4'd0, 1'b0);

        // Latency and almost-empty threshold.
        repeat (4) cyc(gray(1), 4'd0, 1'b0);
        chk("lat_bwptrsyn", 32'(bwptrsyn), 32'd1);
        chk("lat_rd_count1", 32'(rd_count), 32'd1);
        chk("lat_ae1", 32'(almost_empty), 32'd1);
        repeat (4) cyc(gray(2), 4'd0, 1'b0);
        chk("lat_rd_count2", 32'(rd_count), 32'd2);
        chk("lat_ae2", 32'(almost_empty), 32'd0);

        // Wrap-around walk through the full gray sequence.
        for (int i = 3; i <= 17; i++) cyc(gray(i), 4'((i - 2) % MOD), 1'b0);
        repeat (4) cyc(gray(1), 4'd14, 1'b0);
        chk("wrap_bwptrsyn", 32'(bwptrsyn), 32'd1);
        chk("wrap_rd_count", 32'(rd_count), 32'd3);
        chk("wrap_gray_err", 32'(gray_err), 32'd0);

        // Full FIFO, then read pointer wrapped ahead.
        for (int i = 2; i <= 8; i++) cyc(gray(i), 4'd0, 1'b0);
        repeat (4) cyc(gray(8), 4'd0, 1'b0);
        chk("full_rd_count", 32'(rd_count), 32'd8);
        chk("full_ae", 32'(almost_empty), 32'd0);
        chk("full_gray_err", 32'(gray_err), 32'd0);
        repeat (4) cyc(gray(2), 4'd15, 1'b0);
        chk("wrapfull_rd_count", 32'(rd_count), 32'd3);
        chk("jump_gray_err", 32'(gray_err), 32'd1);
        cyc(gray(2), 4'd15, 1'b1);
        chk("clr_gray_err", 32'(gray_err), 32'd0);

        // Coherence error from 0000 -> 0011, then clear, then set-wins.
        repeat (4) cyc(4'b0000, 4'd0, 1'b0);
        cyc(4'b0000, 4'd0, 1'b1);
        repeat (2) cyc(4'b0000, 4'd0, 1'b0);
        chk("base_gray_err", 32'(gray_err), 32'd0);
        cyc(4'b0011, 4'd0, 1'b0);
        cyc(4'b0011, 4'd0, 1'b0);
        chk("coh_syn", 32'(gwptrsyn), 32'd3);
        chk("coh_err_pre", 32'(gray_err), 32'd0);
        cyc(4'b0011, 4'd0, 1'b0);
        chk("coh_err_set", 32'(gray_err), 32'd1);
        cyc(4'b0011, 4'd0, 1'b1);
        chk("coh_err_clr", 32'(gray_err), 32'd0);
        repeat (4) cyc(4'b0000, 4'd0, 1'b0);
        chk("coh_err_again", 32'(gray_err), 32'd1);
        cyc(4'b0011, 4'd0, 1'b0);
        cyc(4'b0011, 4'd0, 1'b0);
        cyc(4'b0011, 4'd0, 1'b1);
        chk("set_wins", 32'(gray_err), 32'd1);
        cyc(4'b0011, 4'd0, 1'b0);
        chk("sticky", 32'(gray_err), 32'd1);

        // Asynchronous reset in the middle of operation.
        cyc(4'b0011, 4'd0, 1'b1);
        for (int i = 3; i <= 5; i++) cyc(gray(i), 4'd0, 1'b0);
        repeat (4) cyc(gray(5), 4'd0, 1'b0);
        chk("pre_rst_rd_count", 32'(rd_count), 32'd5);
        #1;
        r_reset = 1'b0;
        #1;
        chk("async_gwptrsyn", 32'(gwptrsyn), 32'd0);
        chk("async_bwptrsyn", 32'(bwptrsyn), 32'd0);
        chk("async_rd_count", 32'(rd_count), 32'd0);
        chk("async_ae", 32'(almost_empty), 32'd1);
        chk("async_gray_err", 32'(gray_err), 32'd0);
        @(posedge r_clk);
        #2;
        gwptr   = gray(5);
        brptr   = '0;
        err_clr = 1'b0;
        r_reset = 1'b1;
        cyc(gray(5), 4'd0, 1'b0);
        cyc(gray(5), 4'd0, 1'b0);
        chk("post_rst_rd_count_e2", 32'(rd_count), 32'd0);
        cyc(gray(5), 4'd0, 1'b0);
        chk("post_rst_rd_count_e3", 32'(rd_count), 32'd5);

        // Random phase: mostly legal gray steps, occasional jumps and clears.
        wi = 5;
        rb = 0;
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60) wi = (wi + 1) % MOD;
            else if (r < 68) wi = int'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rb = (wi - int'($urandom_range(0, 8)) + MOD) % MOD;
            else if ($urandom_range(0, 29) == 0) rb = int'($urandom_range(0, 15));
            cyc(gray(wi), 4'(rb), ($urandom_range(0, 7) == 0));
        end
        repeat (3) cyc(gray(wi), 4'(rb), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/rd_wptr_sync.md
# rd_wptr_sync

Read-domain receiver for the gray-coded write pointer of the asynchronous FIFO. It synchronizes `gwptr` from the write clock domain into `r_clk` through a configurable flop chain and drives the synchronized gray pointer to the read handler. It also converts that pointer to binary, computes the registered read-side occupancy against the read handler's binary pointer, and raises almost-empty and gray-coherence error flags. It sits between the write-domain pointer register and the read handler.

## Interface
- `N`, default 3: pointer MSB index. Pointers are N+1 bits wide and the FIFO depth is 2^N.
- `SYNC_STAGES`, default 2, legal range 2..4: number of synchronizer flops.
- `AE_LEVEL`, default 1: almost-empty threshold in entries.

- `r_clk`, in, 1: read-domain clock. Rising edge.
- `r_reset`, in, 1: asynchronous, active-low reset.
- `gwptr`, in, N+1: gray write pointer, asynchronous to `r_clk`.
- `brptr`, in, N+1: binary read pointer from the read handler, synchronous to `r_clk`.
- `err_clr`, in, 1: synchronous clear of `gray_err`.
- `gwptrsyn`, out, N+1: synchronized gray write pointer. This is the last synchronizer stage.
- `bwptrsyn`, out, N+1: registered binary form of `gwptrsyn`.
- `rd_count`, out, N+1: registered occupancy, range 0..2^N.
- `almost_empty`, out, 1: registered; asserted when `rd_count` <= `AE_LEVEL`.
- `gray_err`, out, 1: sticky error flag.

## Operation
- **Synchronizer**
  - Chain `s[0]..s[SYNC_STAGES-1]`; `s[0]` samples `gwptr`.
  - `gwptrsyn` = `s[SYNC_STAGES-1]`.
  - No logic is permitted between `gwptr` and `s[0]`.
- **Gray-to-binary conversion**
  - b[N] = g[N].
  - b[i] = b[i+1] ^ g[i], for i = N-1 down to 0.
  - The conversion is combinational from `gwptrsyn`; the result is registered into `bwptrsyn`.
- **Occupancy**
  - `rd_count` is registered as (bin(`gwptrsyn`) − `brptr`) mod 2^(N+1).
  - Both operands are taken on the same edge.
- **Almost-empty**: `almost_empty` is registered as (next `rd_count` <= `AE_LEVEL`).
- **Gray-coherence check**
  - A register `prev` holds the previous `gwptrsyn`.
  - Compute d = popcount(`gwptrsyn` ^ `prev`). Any d > 1 sets `gray_err` on the next edge.
  - Any occupancy result > 2^N also sets `gray_err` on the next edge (overflow, or a read pointer ahead of the write pointer).
  - `gray_err` stays set until `err_clr` is sampled high.
  - If a set condition and `err_clr` occur in the same cycle, set wins.
- **Reset**
  - All synchronizer stages, `prev`, `gwptrsyn`, `bwptrsyn` and `rd_count` reset to 0.
  - `almost_empty` resets to 1; `gray_err` resets to 0.
  - Reset asserted mid-operation clears everything immediately and asynchronously.
  - After release, the first valid `gwptr` reaches `gwptrsyn` after SYNC_STAGES edges.
- **Wrap-around**: all pointer arithmetic is modulo 2^(N+1). No special casing at the MSB toggle.

## Timing
- A `gwptr` value stable before rising edge E appears on `gwptrsyn` after edge E+SYNC_STAGES−1.
  - For the default SYNC_STAGES=2, that is after edge E+1.
- `bwptrsyn`, `rd_count` and `almost_empty` update one edge after `gwptrsyn`. Total latency is SYNC_STAGES+1 edges.
- A `brptr` change at edge E is reflected in `rd_count` and `almost_empty` after edge E+1.
- `gray_err` asserts one edge after the offending `gwptrsyn` value appears.
- `err_clr` high at edge E clears `gray_err` after E, unless a set condition is present at E.
- All outputs are flop outputs. There is no combinational path from input to output.

## Test plan
1. **Reset values.** Assert `r_reset`=0 with `gwptr`=0101 -> `gwptrsyn`=0, `bwptrsyn`=0, `rd_count`=0, `almost_empty`=1, `gray_err`=0, held throughout reset.
2. **Latency** (N=3, SYNC_STAGES=2). With `brptr`=0, step `gwptr` from 0000 to 0001 before edge E -> `gwptrsyn`=0001 after E+1; `bwptrsyn`=1, `rd_count`=1 and `almost_empty`=1 after E+2. Step to 0011 -> `rd_count`=2, `almost_empty`=0.
3. **Wrap-around.** Walk `gwptr` through the gray sequence 0..15 then 0..1 while `brptr`=14 -> final `bwptrsyn`=1 and `rd_count`=3 (from 1−14 mod 16). `gray_err` stays 0 throughout.
4. **Full.** Set `gwptr`=gray(8)=1100 and `brptr`=0 -> `rd_count`=8 (2^N), with no error. Then set `brptr`=15 with `gwptr`=gray(2) -> `rd_count`=3.
5. **Coherence error.** Jump `gwptr` from 0000 to 0011 (two-bit change) -> `gray_err`=1 one edge after `gwptrsyn` updates. Pulse `err_clr` with stable input -> `gray_err`=0 next edge. Apply `err_clr` together with another bad jump -> `gray_err` remains 1.
6. **Reset mid-operation.** With `rd_count`=5, assert `r_reset` asynchronously between edges -> all outputs return to their reset values immediately. Release with `gwptr`=gray(5) and `brptr`=0 -> `rd_count`=5 after SYNC_STAGES+1 edges.
